// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the slave receiver and its register-bank consumer.
// Contents:
//   state_e     register-bank protocol states
//   BYTE_W      width of one I2C data byte
//   SLAVE_ADDR  7-bit I2C slave address answered by this design
package i2c_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [6:0] SLAVE_ADDR = 7'h69;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } state_e;

endpackage

// File: rtl/rise_detect.sv
// Single-bit registered rising-edge detector.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset (history clears to 0)
//   sig    level input
//   rise   high for the cycle in which sig is 1 and was 0 at the previous edge
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/i2c_reg_bank.sv
// Write-only I2C register bank. The first byte after START selects a register; the
// following bytes are written starting at that register.
// Configuration macro: I2C_REG_AUTOINC_EN -- when defined the pointer advances
// (mod NUM_REGS) after every data write; otherwise it is held.
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   data_i        received byte, stable while data_valid_i is high
//   data_valid_i  byte-valid level; its rising edge marks a new byte
//   start_i       START / repeated START level (edge-detected)
//   stop_i        STOP level (sampled directly)
//   regs_o        flattened registers, register k at [8k+7:8k]
//   wr_strobe_o   one-cycle pulse after each register write
//   wr_addr_o     index written, valid with wr_strobe_o
//   ptr_err_o     sticky out-of-range pointer flag
module i2c_reg_bank
    import i2c_pkg::*;
#(
    parameter int unsigned        NUM_REGS  = 8,
    parameter int unsigned        PTR_W     = 3,
    parameter logic [BYTE_W-1:0]  RESET_VAL = 8'h00
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [BYTE_W-1:0]          data_i,
    input  logic                       data_valid_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    output logic [NUM_REGS*BYTE_W-1:0] regs_o,
    output logic                       wr_strobe_o,
    output logic [PTR_W-1:0]           wr_addr_o,
    output logic                       ptr_err_o
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REGS - 1);

    logic byte_ev;
    logic start_ev;

    rise_detect u_dv_rise (
        .clk   (clk),
        .reset (reset),
        .sig   (data_valid_i),
        .rise  (byte_ev)
    );

    rise_detect u_start_rise (
        .clk   (clk),
        .reset (reset),
        .sig   (start_i),
        .rise  (start_ev)
    );

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [BYTE_W-1:0] regs_q [NUM_REGS];
    logic [BYTE_W-1:0] regs_d [NUM_REGS];
    logic              strobe_q, strobe_d;
    logic [PTR_W-1:0]  waddr_q, waddr_d;
    logic              err_q, err_d;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        regs_d   = regs_q;
        strobe_d = 1'b0;
        waddr_d  = waddr_q;
        err_d    = err_q;

        if (start_ev) begin
            // A byte landing in the same cycle as START is discarded.
            state_d = PTR;
        end else begin
            if (byte_ev) begin
                unique case (state_q)
                    PTR: begin
                        if (32'(data_i) < NUM_REGS) begin
                            ptr_d   = data_i[PTR_W-1:0];
                            state_d = DATA;
                        end else begin
                            err_d   = 1'b1;
                            state_d = DROP;
                        end
                    end
                    DATA: begin
                        regs_d[ptr_q] = data_i;
                        strobe_d      = 1'b1;
                        waddr_d       = ptr_q;
`ifdef I2C_REG_AUTOINC_EN
                        ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
`endif
                    end
                    IDLE, DROP: begin
                    end
                    default: begin
                    end
                endcase
            end
            // A byte coinciding with STOP is still processed above.
            if (stop_i) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            strobe_q <= 1'b0;
            waddr_q  <= '0;
            err_q    <= 1'b0;
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                regs_q[k] <= RESET_VAL;
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            strobe_q <= strobe_d;
            waddr_q  <= waddr_d;
            err_q    <= err_d;
            regs_q   <= regs_d;
        end
    end

    for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_flat
        assign regs_o[k*BYTE_W +: BYTE_W] = regs_q[k];
    end

    assign wr_strobe_o = strobe_q;
    assign wr_addr_o   = waddr_q;
    assign ptr_err_o   = err_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
module tb_i2c_reg_bank;

    logic        clk;
    logic        reset;
    logic [7:0]  data_i;
    logic        data_valid_i;
    logic        start_i;
    logic        stop_i;
    logic [63:0] regs_o;
    logic        wr_strobe_o;
    logic [2:0]  wr_addr_o;
    logic        ptr_err_o;

    i2c_reg_bank #(
        .NUM_REGS  (8),
        .PTR_W     (3),
        .RESET_VAL (8'h00)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .regs_o       (regs_o),
        .wr_strobe_o  (wr_strobe_o),
        .wr_addr_o    (wr_addr_o),
        .ptr_err_o    (ptr_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned checks = 0;
    int unsigned passed = 0;

    // Strobe monitor, sampled on the inactive edge.
    int unsigned strobe_cnt = 0;
    logic [2:0]  addr_log [$];

    always @(negedge clk) begin
        if (wr_strobe_o) begin
            strobe_cnt++;
            addr_log.push_back(wr_addr_o);
        end
    end

    // Hand-maintained expected register image.
    logic [7:0] exp_regs [8];

    function automatic logic [63:0] exp_flat();
        logic [63:0] f;
        for (int k = 0; k < 8; k++) f[k*8 +: 8] = exp_regs[k];
        return f;
    endfunction

    task automatic clear_log();
        strobe_cnt = 0;
        addr_log.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
    endtask

    task automatic send_stop();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        data_i       = b;
        data_valid_i = 1'b1;
        repeat (hold) tick();
        data_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        data_i       = 8'h00;
        data_valid_i = 1'b0;
        start_i      = 1'b0;
        stop_i       = 1'b0;
        for (int k = 0; k < 8; k++) exp_regs[k] = 8'h00;
        repeat (2) tick();
        checks++; if (regs_o !== 64'h0) $display("FAIL reset_regs got=%h exp=%h", regs_o, 64'h0);
        else passed++;
        checks++; if (wr_strobe_o !== 1'b0) $display("FAIL reset_strobe got=%b exp=0", wr_strobe_o);
        else passed++;
        checks++; if (wr_addr_o !== 3'd0) $display("FAIL reset_addr got=%0d exp=0", wr_addr_o);
        else passed++;
        checks++; if (ptr_err_o !== 1'b0) $display("FAIL reset_err got=%b exp=0", ptr_err_o);
        else passed++;
        reset = 1'b0;
        tick();
        clear_log();
    endtask

    task automatic test_basic_write();
        clear_log();
        send_start();
        send_byte(8'h02, 1);
        send_byte(8'hA5, 1);
        send_stop();
        exp_regs[2] = 8'hA5;
        checks++; if (regs_o !== 64'h0000_0000_00A5_0000)
            $display("FAIL basic_regs got=%h exp=%h", regs_o, 64'h0000_0000_00A5_0000);
        else passed++;
        checks++; if (strobe_cnt !== 1) $display("FAIL basic_strobes got=%0d exp=1", strobe_cnt);
        else passed++;
        checks++; if (addr_log[0] !== 3'd2) $display("FAIL basic_addr got=%0d exp=2", addr_log[0]);
        else passed++;
    endtask

    task automatic test_burst();
        logic [8:0] addrs;
        logic [8:0] exp_addrs;
        clear_log();
        send_start();
        send_byte(8'h06, 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        send_byte(8'h33, 1);
        send_stop();
`ifdef I2C_REG_AUTOINC_EN
        exp_regs[6] = 8'h11;
        exp_regs[7] = 8'h22;
        exp_regs[0] = 8'h33;
        exp_addrs   = {3'd6, 3'd7, 3'd0};
`else
        exp_regs[6] = 8'h33;
        exp_addrs   = {3'd6, 3'd6, 3'd6};
`endif
        checks++; if (regs_o !== exp_flat())
            $display("FAIL burst_regs got=%h exp=%h", regs_o, exp_flat());
        else passed++;
        checks++; if (strobe_cnt !== 3) $display("FAIL burst_strobes got=%0d exp=3", strobe_cnt);
        else passed++;
        addrs = {addr_log[0], addr_log[1], addr_log[2]};
        checks++; if (addrs !== exp_addrs)
            $display("FAIL burst_addrs got=%o exp=%o", addrs, exp_addrs);
        else passed++;
    endtask

    task automatic test_bad_ptr();
        clear_log();
        send_start();
        send_byte(8'h09, 1);
        send_byte(8'hFF, 1);
        checks++; if (ptr_err_o !== 1'b1) $display("FAIL badptr_err got=%b exp=1", ptr_err_o);
        else passed++;
        checks++; if (strobe_cnt !== 0) $display("FAIL badptr_strobes got=%0d exp=0", strobe_cnt);
        else passed++;
        checks++; if (regs_o !== exp_flat())
            $display("FAIL badptr_regs got=%h exp=%h", regs_o, exp_flat());
        else passed++;
        send_start();
        send_byte(8'h01, 1);
        send_byte(8'h5A, 1);
        send_stop();
        exp_regs[1] = 8'h5A;
        checks++; if (regs_o !== exp_flat())
            $display("FAIL recover_regs got=%h exp=%h", regs_o, exp_flat());
        else passed++;
        checks++; if (ptr_err_o !== 1'b1) $display("FAIL sticky_err got=%b exp=1", ptr_err_o);
        else passed++;
    endtask

    task automatic test_held_valid();
        clear_log();
        send_start();
        send_byte(8'h04, 1);
        send_byte(8'h3C, 20);
        send_stop();
        exp_regs[4] = 8'h3C;
        checks++; if (strobe_cnt !== 1) $display("FAIL held_strobes got=%0d exp=1", strobe_cnt);
        else passed++;
        checks++; if (addr_log[0] !== 3'd4) $display("FAIL held_addr got=%0d exp=4", addr_log[0]);
        else passed++;
        checks++; if (regs_o !== exp_flat())
            $display("FAIL held_regs got=%h exp=%h", regs_o, exp_flat());
        else passed++;
    endtask

    task automatic test_repeated_start();
        logic [5:0] addrs;
        clear_log();
        // Bytes while idle must be ignored.
        send_byte(8'h01, 1);
        send_byte(8'hEE, 1);
        send_start();
        send_byte(8'h03, 1);
        send_byte(8'h44, 1);
        send_start();
        send_byte(8'h05, 1);
        send_byte(8'h66, 1);
        send_stop();
        exp_regs[3] = 8'h44;
        exp_regs[5] = 8'h66;
        checks++; if (regs_o !== exp_flat())
            $display("FAIL rstart_regs got=%h exp=%h", regs_o, exp_flat());
        else passed++;
        checks++; if (strobe_cnt !== 2) $display("FAIL rstart_strobes got=%0d exp=2", strobe_cnt);
        else passed++;
        addrs = {addr_log[0], addr_log[1]};
        checks++; if (addrs !== {3'd3, 3'd5})
            $display("FAIL rstart_addrs got=%o exp=%o", addrs, 6'o35);
        else passed++;
    endtask

    task automatic test_stop_with_byte();
        clear_log();
        send_start();
        send_byte(8'h07, 1);
        // Data byte rises in the same cycle as STOP: written, then idle.
        data_i       = 8'h99;
        data_valid_i = 1'b1;
        stop_i       = 1'b1;
        tick();
        data_valid_i = 1'b0;
        stop_i       = 1'b0;
        tick();
        send_byte(8'h12, 1);
        tick();
        exp_regs[7] = 8'h99;
        checks++; if (regs_o !== exp_flat())
            $display("FAIL stopbyte_regs got=%h exp=%h", regs_o, exp_flat());
        else passed++;
        checks++; if (strobe_cnt !== 1) $display("FAIL stopbyte_strobes got=%0d exp=1", strobe_cnt);
        else passed++;
    endtask

    task automatic test_async_reset();
        clear_log();
        send_start();
        send_byte(8'h04, 1);
        // Mid-cycle, no clock edge between assertion and the checks.
        reset = 1'b1;
        #1;
        checks++; if (regs_o !== 64'h0) $display("FAIL areset_regs got=%h exp=%h", regs_o, 64'h0);
        else passed++;
        checks++; if (ptr_err_o !== 1'b0) $display("FAIL areset_err got=%b exp=0", ptr_err_o);
        else passed++;
        checks++; if (wr_strobe_o !== 1'b0) $display("FAIL areset_strobe got=%b exp=0", wr_strobe_o);
        else passed++;
        checks++; if (wr_addr_o !== 3'd0) $display("FAIL areset_addr got=%0d exp=0", wr_addr_o);
        else passed++;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        clear_log();
        send_byte(8'h77, 1);
        tick();
        checks++; if (regs_o !== 64'h0) $display("FAIL postreset_regs got=%h exp=%h", regs_o, 64'h0);
        else passed++;
        checks++; if (strobe_cnt !== 0) $display("FAIL postreset_strobes got=%0d exp=0", strobe_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_burst();
        test_bad_ptr();
        test_held_valid();
        test_repeated_start();
        test_stop_with_byte();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
